gsr_pur_assign_block: RTL and testbench

Generates the device-wide active-low global set/reset (GSR) and power-up reset (PUR) nets consumed by every I/O and register primitive (e.g. the ODDR serializers). Also produces the combined per-cell reset enable, SRN. PUR is released a fixed number of clocks after power-on reset. GSR follows a user request, is stretched to a minimum width, and is released synchronously.

---
 rtl/gsr_pur_assign_block_pkg.sv | 10 +
 rtl/gsr_pur_assign_block_reset_sync_stretch.sv | 68 ++++++
 rtl/gsr_pur_assign_block.sv | 60 ++++++
 tb/tb_gsr_pur_assign_block.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gsr_pur_assign_block_pkg.sv
// Shared constants for the global set/reset and power-up reset generator.
package gsr_pur_assign_block_pkg;

    localparam int unsigned PUR_CNT_W = 16;
    localparam int unsigned GSR_CNT_W = 8;

    localparam string GSR_ENABLED  = "ENABLED";
    localparam string GSR_DISABLED = "DISABLED";

endpackage

// File: rtl/gsr_pur_assign_block_reset_sync_stretch.sv
// Active-low reset with asynchronous assertion, synchronized release and a
// minimum asserted width counted in clk edges since the latest assertion.
module reset_sync_stretch
    import gsr_pur_assign_block_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_CYCLES  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_n,
    input  logic release_ok,
    output logic rst_out_n
);

    localparam int unsigned CHAIN_W = SYNC_STAGES - 1;

    logic               req_ok;
    logic               arst_n;
    logic [CHAIN_W-1:0] sync_q, sync_d;
    logic               seen_q;
    logic               restart;
    logic [GSR_CNT_W-1:0] cnt_q, cnt_d;
    logic               out_q, out_d;

    // Unknown or floating request counts as asserted.
    assign req_ok = (req_n === 1'b1);
    assign arst_n = rst_n & req_ok;

    // The output flop is the last synchronizer stage, so release lands on
    // the SYNC_STAGES-th edge after the request goes high.
    assign restart = ~sync_q[0] & seen_q;

    always_comb begin
        sync_d = CHAIN_W'({sync_q, 1'b1});
        cnt_d  = cnt_q;
        if (restart) begin
            cnt_d = GSR_CNT_W'(1);
        end else if (cnt_q < GSR_CNT_W'(MIN_CYCLES)) begin
            cnt_d = cnt_q + GSR_CNT_W'(1);
        end
        out_d = out_q | (sync_q[CHAIN_W-1] & (cnt_d >= GSR_CNT_W'(MIN_CYCLES)) & release_ok);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= '0;
            out_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            out_q  <= out_d;
        end
    end

    // Width tracking must keep running while the request is held low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            seen_q <= sync_q[0];
            cnt_q  <= cnt_d;
        end
    end

    assign rst_out_n = out_q;

endmodule

// File: rtl/gsr_pur_assign_block.sv
// Device-wide GSR/PUR net generator with combined per-cell reset enable.
module gsr_pur_assign_block
    import gsr_pur_assign_block_pkg::*;
#(
    parameter string       GSR            = "ENABLED",
    parameter int unsigned PUR_CYCLES     = 16,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned GSR_MIN_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic gsr_req_n,
    output logic pur_net,
    output logic gsr_net,
    output logic srn,
    output logic pur_done
);

    localparam bit GSR_OFF = (GSR == GSR_DISABLED);

    logic [PUR_CNT_W-1:0] pur_cnt_q, pur_cnt_d;
    logic                 pur_q, pur_d;
    logic                 gsr_n;

    // Saturating power-up counter; PUR releases on the edge the count lands.
    always_comb begin
        pur_cnt_d = pur_cnt_q;
        if (pur_cnt_q < PUR_CNT_W'(PUR_CYCLES)) begin
            pur_cnt_d = pur_cnt_q + PUR_CNT_W'(1);
        end
        pur_d = pur_q | (pur_cnt_d == PUR_CNT_W'(PUR_CYCLES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pur_cnt_q <= '0;
            pur_q     <= 1'b0;
        end else begin
            pur_cnt_q <= pur_cnt_d;
            pur_q     <= pur_d;
        end
    end

    reset_sync_stretch #(
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_CYCLES  (GSR_MIN_CYCLES)
    ) u_gsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_n      (gsr_req_n),
        .release_ok (pur_d),
        .rst_out_n  (gsr_n)
    );

    assign pur_net  = pur_q;
    assign pur_done = pur_q;
    assign gsr_net  = gsr_n;
    assign srn      = GSR_OFF ? pur_q : (gsr_n & pur_q);

endmodule

// File: tb/tb_gsr_pur_assign_block.sv
// Directed bench for gsr_pur_assign_block, one ENABLED and one DISABLED instance.
module tb_gsr_pur_assign_block;

    logic clk = 1'b0;
    logic rst_n;
    logic req_a_n;
    logic req_b_n;
    logic pur_a, gsr_a, srn_a, done_a;
    logic pur_b, gsr_b, srn_b, done_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [3:0] exp;
        bit         sel;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    gsr_pur_assign_block dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .gsr_req_n (req_a_n),
        .pur_net   (pur_a),
        .gsr_net   (gsr_a),
        .srn       (srn_a),
        .pur_done  (done_a)
    );

    gsr_pur_assign_block #(.GSR("DISABLED")) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .gsr_req_n (req_b_n),
        .pur_net   (pur_b),
        .gsr_net   (gsr_b),
        .srn       (srn_b),
        .pur_done  (done_b)
    );

    // Vector order: {pur_net, gsr_net, srn, pur_done}
    function automatic logic [3:0] obs(input bit sel);
        return sel ? {pur_b, gsr_b, srn_b, done_b} : {pur_a, gsr_a, srn_a, done_a};
    endfunction

    task automatic push(input string tag, input logic [3:0] e, input bit sel);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        x.sel = sel;
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        logic [3:0] o;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            o = obs(x.sel);
            checks++;
            assert (o === x.exp) else begin
                errors++;
                $error("FAIL %s observed=%b expected=%b", x.tag, o, x.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pur_run(input string name, input int n);
        for (int k = 1; k <= n; k++) begin
            tick();
            push($sformatf("%s_a_e%0d", name, k), (k >= 16) ? 4'b1111 : 4'b0000, 1'b0);
            push($sformatf("%s_b_e%0d", name, k), (k >= 16) ? 4'b1111 : 4'b0000, 1'b1);
            drain();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        req_a_n = 1'b1;
        req_b_n = 1'b1;
        #1;
        push("reset_a", 4'b0000, 1'b0);
        push("reset_b", 4'b0000, 1'b1);
        drain();
        for (int i = 0; i < 3; i++) tick();

        // Power-up: release lands on edge 16
        rst_n = 1'b1;
        pur_run("powerup", 18);

        // GSR pulse of 10 clocks
        req_a_n = 1'b0;
        #1;
        push("pulse_immediate", 4'b1001, 1'b0);
        drain();
        for (int k = 1; k <= 10; k++) begin
            tick();
            push($sformatf("pulse_hold_e%0d", k), 4'b1001, 1'b0);
            drain();
        end
        req_a_n = 1'b1;
        tick();
        push("pulse_rel_e1", 4'b1001, 1'b0);
        drain();
        tick();
        push("pulse_rel_e2", 4'b1111, 1'b0);
        push("pulse_b_untouched", 4'b1111, 1'b1);
        drain();

        // Sub-clock glitch is stretched to 4 clocks
        tick();
        tick();
        req_a_n = 1'b0;
        #1;
        push("glitch_immediate", 4'b1001, 1'b0);
        drain();
        req_a_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            push($sformatf("glitch_e%0d", k), (k >= 4) ? 4'b1111 : 4'b1001, 1'b0);
            drain();
        end

        // Re-assertion during stretching restarts the width count
        req_a_n = 1'b0;
        #1;
        req_a_n = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            push($sformatf("restart_first_e%0d", k), 4'b1001, 1'b0);
            drain();
        end
        req_a_n = 1'b0;
        #1;
        req_a_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            push($sformatf("restart_second_e%0d", k), (k >= 4) ? 4'b1111 : 4'b1001, 1'b0);
            drain();
        end

        // DISABLED instance ignores GSR on srn
        req_b_n = 1'b0;
        #1;
        push("disabled_immediate", 4'b1011, 1'b1);
        push("disabled_a_untouched", 4'b1111, 1'b0);
        drain();
        for (int k = 1; k <= 6; k++) begin
            tick();
            push($sformatf("disabled_hold_e%0d", k), 4'b1011, 1'b1);
            drain();
        end
        req_b_n = 1'b1;
        tick();
        push("disabled_rel_e1", 4'b1011, 1'b1);
        drain();
        tick();
        push("disabled_rel_e2", 4'b1111, 1'b1);
        drain();

        // Reset assertion mid-operation, then again at PUR count 8
        rst_n = 1'b0;
        #1;
        push("midreset_a", 4'b0000, 1'b0);
        push("midreset_b", 4'b0000, 1'b1);
        drain();
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            push($sformatf("count8_e%0d", k), 4'b0000, 1'b0);
            drain();
        end
        rst_n = 1'b0;
        #1;
        push("count8_reset_a", 4'b0000, 1'b0);
        push("count8_reset_b", 4'b0000, 1'b1);
        drain();
        tick();
        tick();
        rst_n = 1'b1;
        pur_run("rerun", 17);

        // Request held low across power-up until clock 30
        rst_n   = 1'b0;
        req_a_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            push($sformatf("req_during_pur_e%0d", k), (k >= 16) ? 4'b1001 : 4'b0000, 1'b0);
            drain();
        end
        req_a_n = 1'b1;
        tick();
        push("req_during_pur_e31", 4'b1001, 1'b0);
        drain();
        tick();
        push("req_during_pur_e32", 4'b1111, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
